// File: rtl/exu_wb_arb.sv
// exu_wb_arb: shares the single register-file write port between the ALU
// (fixed latency, never stalls) and the MUL/DIV units (valid/ready). Each
// multi-cycle unit owns a small result FIFO. The ALU always wins the port,
// and the two FIFOs are served round-robin when the ALU is idle. A starvation
// monitor asks the IDU for a bubble when a FIFO has waited too long.
module exu_wb_arb #(
  parameter int XLEN         = 32,
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 8
) (
  input  logic            clk,
  input  logic            rst,
  // ALU result stage
  input  logic            alu_wr_en,
  input  logic [4:0]      alu_rd_addr,
  input  logic [XLEN-1:0] alu_data,
  input  logic [XLEN-1:0] alu_tag,
  // MUL result interface
  input  logic            mul_valid,
  output logic            mul_ready,
  input  logic [4:0]      mul_rd_addr,
  input  logic [XLEN-1:0] mul_data,
  input  logic [XLEN-1:0] mul_tag,
  // DIV result interface
  input  logic            div_valid,
  output logic            div_ready,
  input  logic [4:0]      div_rd_addr,
  input  logic [XLEN-1:0] div_data,
  input  logic [XLEN-1:0] div_tag,
  // register-file write port and retirement report
  output logic            rf_wr_en,
  output logic [4:0]      rf_wr_addr,
  output logic [XLEN-1:0] rf_wr_data,
  output logic            wb_valid,
  output logic [XLEN-1:0] wb_tag,
  output logic [1:0]      wb_src,
  output logic            idu_stall_req
);

  // Index 0 is MUL, index 1 is DIV throughout.
  localparam int NU = 2;
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam int EW = 5 + 2 * XLEN;
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  localparam logic [1:0] SRC_NONE = 2'b00;
  localparam logic [1:0] SRC_ALU  = 2'b01;
  localparam logic [1:0] SRC_MUL  = 2'b10;
  localparam logic [1:0] SRC_DIV  = 2'b11;

  // An FIFO entry is {rd, data, tag}.
  logic [NU-1:0] in_valid;
  logic [EW-1:0] in_entry [NU];
  logic [EW-1:0] head_entry [NU];
  logic [NU-1:0] fifo_ready;
  logic [NU-1:0] not_empty;
  logic [NU-1:0] starving;
  logic [NU-1:0] grant;

  logic          alu_req;
  logic          last_grant_reg;   // 0 = MUL, 1 = DIV
  logic [EW-1:0] sel_entry;
  logic [4:0]    sel_rd;

  assign in_valid    = {div_valid, mul_valid};
  assign in_entry[0] = {mul_rd_addr, mul_data, mul_tag};
  assign in_entry[1] = {div_rd_addr, div_data, div_tag};
  assign mul_ready   = fifo_ready[0];
  assign div_ready   = fifo_ready[1];

  // A write to x0 is not a request; the ALU result is simply dropped.
  assign alu_req = alu_wr_en && (alu_rd_addr != 5'd0);

  // Grant from start-of-cycle FIFO state: ALU first, then round-robin.
  always_comb begin
    grant = '0;
    if (!alu_req) begin
      if (&not_empty) begin
        if (last_grant_reg) begin
          grant[0] = 1'b1;
        end else begin
          grant[1] = 1'b1;
        end
      end else begin
        grant = not_empty;
      end
    end
  end

  assign sel_entry = grant[1] ? head_entry[1] : head_entry[0];
  assign sel_rd    = sel_entry[EW-1 -: 5];

  generate
    for (genvar gi = 0; gi < NU; gi++) begin : g_fifo
      logic [EW-1:0]   mem [DEPTH];
      logic [PW-1:0]   wr_ptr_reg;
      logic [PW-1:0]   rd_ptr_reg;
      logic [CW-1:0]   cnt_reg;
      logic            full;
      logic            push;

      // Pointers carry one extra wrap bit so full and empty are distinguishable.
      assign full = (wr_ptr_reg[PW-1] != rd_ptr_reg[PW-1]) &&
                    (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
      assign not_empty[gi]  = (wr_ptr_reg != rd_ptr_reg);
      assign fifo_ready[gi] = !full;
      assign push           = in_valid[gi] && !full;
      assign head_entry[gi] = mem[rd_ptr_reg[AW-1:0]];
      assign starving[gi]   = (cnt_reg == LIMIT);

      // Entry storage; contents need no reset because the pointers define validity.
      always_ff @(posedge clk) begin
        if (push) begin
          mem[wr_ptr_reg[AW-1:0]] <= in_entry[gi];
        end
      end

      // Tail advances on an accepted push, head advances when this FIFO is granted.
      always_ff @(posedge clk) begin
        if (rst) begin
          wr_ptr_reg <= '0;
          rd_ptr_reg <= '0;
        end else begin
          if (push) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
          end
          if (grant[gi]) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
          end
        end
      end

      // Count consecutive denied cycles while holding data, saturating at the limit.
      always_ff @(posedge clk) begin
        if (rst || !not_empty[gi] || grant[gi]) begin
          cnt_reg <= '0;
        end else if (cnt_reg != LIMIT) begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end
    end
  endgenerate

  assign idu_stall_req = |starving;

  // Registered write port: one cycle from grant; address/data/tag hold when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_wr_en       <= 1'b0;
      rf_wr_addr     <= '0;
      rf_wr_data     <= '0;
      wb_valid       <= 1'b0;
      wb_tag         <= '0;
      wb_src         <= SRC_NONE;
      last_grant_reg <= 1'b1;
    end else if (alu_req) begin
      rf_wr_en   <= 1'b1;
      rf_wr_addr <= alu_rd_addr;
      rf_wr_data <= alu_data;
      wb_valid   <= 1'b1;
      wb_tag     <= alu_tag;
      wb_src     <= SRC_ALU;
    end else if (|grant) begin
      // x0 entries still retire, they just never touch the register file.
      rf_wr_en       <= (sel_rd != 5'd0);
      rf_wr_addr     <= sel_rd;
      rf_wr_data     <= sel_entry[2*XLEN-1:XLEN];
      wb_valid       <= 1'b1;
      wb_tag         <= sel_entry[XLEN-1:0];
      wb_src         <= grant[1] ? SRC_DIV : SRC_MUL;
      last_grant_reg <= grant[1];
    end else begin
      rf_wr_en <= 1'b0;
      wb_valid <= 1'b0;
      wb_src   <= SRC_NONE;
    end
  end

endmodule

// File: tb/tb_exu_wb_arb.sv
// Testbench for exu_wb_arb: a directed vector table, hand-written corner
// sequences, and randomized traffic checked against a queue-based model.
module tb_exu_wb_arb;
  localparam int XLEN  = 32;
  localparam int DEPTH = 2;
  localparam int LIMIT = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            alu_wr_en;
  logic [4:0]      alu_rd_addr;
  logic [XLEN-1:0] alu_data, alu_tag;
  logic            mul_valid, mul_ready;
  logic [4:0]      mul_rd_addr;
  logic [XLEN-1:0] mul_data, mul_tag;
  logic            div_valid, div_ready;
  logic [4:0]      div_rd_addr;
  logic [XLEN-1:0] div_data, div_tag;
  logic            rf_wr_en;
  logic [4:0]      rf_wr_addr;
  logic [XLEN-1:0] rf_wr_data;
  logic            wb_valid;
  logic [XLEN-1:0] wb_tag;
  logic [1:0]      wb_src;
  logic            idu_stall_req;

  always #5 clk = ~clk;

  exu_wb_arb #(.XLEN(XLEN), .DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .alu_wr_en(alu_wr_en), .alu_rd_addr(alu_rd_addr), .alu_data(alu_data), .alu_tag(alu_tag),
    .mul_valid(mul_valid), .mul_ready(mul_ready), .mul_rd_addr(mul_rd_addr),
    .mul_data(mul_data), .mul_tag(mul_tag),
    .div_valid(div_valid), .div_ready(div_ready), .div_rd_addr(div_rd_addr),
    .div_data(div_data), .div_tag(div_tag),
    .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_src(wb_src), .idu_stall_req(idu_stall_req)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { logic [4:0] rd; logic [XLEN-1:0] data; logic [XLEN-1:0] tag; } ent_t;
  ent_t mq[$];
  ent_t dq[$];
  int   mcnt, dcnt;
  bit   last_was_div;
  logic            e_en, e_valid;
  logic [1:0]      e_src;
  logic [4:0]      e_addr;
  logic [XLEN-1:0] e_data, e_tag;

  task automatic model_reset();
    mq.delete(); dq.delete();
    mcnt = 0; dcnt = 0; last_was_div = 1'b1;
    e_en = 0; e_valid = 0; e_src = 2'b00; e_addr = '0; e_data = '0; e_tag = '0;
  endtask

  task automatic retire(input ent_t e, input logic [1:0] src);
    e_en = (e.rd != 0); e_valid = 1; e_src = src;
    e_addr = e.rd; e_data = e.data; e_tag = e.tag;
  endtask

  // One clock: check ready, predict, clock, compare registered outputs.
  task automatic step();
    bit m_had, d_had, m_push, d_push;
    int who;   // 0 none, 1 ALU, 2 MUL, 3 DIV
    ent_t e;
    chk("mul_ready", mul_ready, mq.size() < DEPTH);
    chk("div_ready", div_ready, dq.size() < DEPTH);
    if (rst) begin
      model_reset();
    end else begin
      m_had  = mq.size() > 0;
      d_had  = dq.size() > 0;
      m_push = mul_valid && (mq.size() < DEPTH);
      d_push = div_valid && (dq.size() < DEPTH);
      who = 0;
      if (alu_wr_en && alu_rd_addr != 0) who = 1;
      else if (m_had && d_had)           who = last_was_div ? 2 : 3;
      else if (m_had)                    who = 2;
      else if (d_had)                    who = 3;
      case (who)
        1: begin
          e_en = 1; e_valid = 1; e_src = 2'b01;
          e_addr = alu_rd_addr; e_data = alu_data; e_tag = alu_tag;
        end
        2: begin e = mq.pop_front(); retire(e, 2'b10); last_was_div = 0; end
        3: begin e = dq.pop_front(); retire(e, 2'b11); last_was_div = 1; end
        default: begin e_en = 0; e_valid = 0; e_src = 2'b00; end
      endcase
      mcnt = (m_had && who != 2) ? ((mcnt < LIMIT) ? mcnt + 1 : LIMIT) : 0;
      dcnt = (d_had && who != 3) ? ((dcnt < LIMIT) ? dcnt + 1 : LIMIT) : 0;
      if (m_push) mq.push_back('{mul_rd_addr, mul_data, mul_tag});
      if (d_push) dq.push_back('{div_rd_addr, div_data, div_tag});
    end
    @(posedge clk); #1;
    chk("rf_wr_en",   rf_wr_en,   e_en);
    chk("wb_valid",   wb_valid,   e_valid);
    chk("wb_src",     wb_src,     e_src);
    chk("rf_wr_addr", rf_wr_addr, e_addr);
    chk("rf_wr_data", rf_wr_data, e_data);
    chk("wb_tag",     wb_tag,     e_tag);
    chk("idu_stall",  idu_stall_req, (mcnt == LIMIT) || (dcnt == LIMIT));
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic all_idle();
    alu_wr_en = 0; alu_rd_addr = 0; alu_data = 0; alu_tag = 0;
    mul_valid = 0; mul_rd_addr = 0; mul_data = 0; mul_tag = 0;
    div_valid = 0; div_rd_addr = 0; div_data = 0; div_tag = 0;
  endtask

  task automatic alu_busy();
    alu_wr_en = 1; alu_rd_addr = 5'($urandom_range(1, 31));
    alu_data = $urandom; alu_tag = $urandom;
  endtask

  task automatic do_reset();
    rst = 1; step(); rst = 0;
  endtask

  typedef struct {
    logic alu_en; logic [4:0] alu_rd; logic [XLEN-1:0] alu_d, alu_t;
    logic mv; logic [4:0] mrd; logic [XLEN-1:0] md, mt;
    logic dv; logic [4:0] drd; logic [XLEN-1:0] dd, dt;
    logic x_en, x_valid; logic [1:0] x_src; logic [4:0] x_addr; logic [XLEN-1:0] x_data, x_tag;
  } vec_t;

  vec_t vec [9];
  bit   seen;
  bit   m_pend, d_pend, m_acc, d_acc;
  int   alu_pct;

  initial begin
    // Directed vectors applied back to back from reset; expectations one cycle later.
    vec[0] = '{1, 5, 32'h1234, 32'h1, 0, 0, 0, 0, 0, 0, 0, 0,           1, 1, 2'b01, 5, 32'h1234, 32'h1};
    vec[1] = '{1, 0, 32'h5555, 32'h2, 0, 0, 0, 0, 0, 0, 0, 0,           0, 0, 2'b00, 5, 32'h1234, 32'h1};
    vec[2] = '{0, 0, 0, 0, 1, 7, 32'hAAAA, 32'h3, 1, 9, 32'hBBBB, 32'h4, 0, 0, 2'b00, 5, 32'h1234, 32'h1};
    vec[3] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,                     1, 1, 2'b10, 7, 32'hAAAA, 32'h3};
    vec[4] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,                     1, 1, 2'b11, 9, 32'hBBBB, 32'h4};
    vec[5] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'hCCCC, 32'h5,          0, 0, 2'b00, 9, 32'hBBBB, 32'h4};
    vec[6] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,                     0, 1, 2'b11, 0, 32'hCCCC, 32'h5};
    vec[7] = '{1, 4, 32'h4444, 32'h7, 1, 3, 32'h3333, 32'h6, 0, 0, 0, 0, 1, 1, 2'b01, 4, 32'h4444, 32'h7};
    vec[8] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,                     1, 1, 2'b10, 3, 32'h3333, 32'h6};

    all_idle();
    rst = 1;
    @(posedge clk); #1;
    model_reset();
    rst = 0;
    chk("reset_rf_wr_en", rf_wr_en, 0);
    chk("reset_wb_valid", wb_valid, 0);
    chk("reset_wb_src",   wb_src, 0);
    chk("reset_stall",    idu_stall_req, 0);
    chk("reset_mul_ready", mul_ready, 1);
    chk("reset_div_ready", div_ready, 1);

    // ---- vector table ----
    for (int i = 0; i < 9; i++) begin
      alu_wr_en = vec[i].alu_en; alu_rd_addr = vec[i].alu_rd;
      alu_data = vec[i].alu_d; alu_tag = vec[i].alu_t;
      mul_valid = vec[i].mv; mul_rd_addr = vec[i].mrd; mul_data = vec[i].md; mul_tag = vec[i].mt;
      div_valid = vec[i].dv; div_rd_addr = vec[i].drd; div_data = vec[i].dd; div_tag = vec[i].dt;
      step();
      chk($sformatf("vec%0d_en", i),    rf_wr_en,   vec[i].x_en);
      chk($sformatf("vec%0d_valid", i), wb_valid,   vec[i].x_valid);
      chk($sformatf("vec%0d_src", i),   wb_src,     vec[i].x_src);
      chk($sformatf("vec%0d_addr", i),  rf_wr_addr, vec[i].x_addr);
      chk($sformatf("vec%0d_data", i),  rf_wr_data, vec[i].x_data);
      chk($sformatf("vec%0d_tag", i),   wb_tag,     vec[i].x_tag);
    end
    all_idle();

    // ---- fill MUL FIFO while the ALU owns the port; third result must survive ----
    do_reset();
    alu_busy(); mul_valid = 1; mul_rd_addr = 10; mul_data = 32'hD1; mul_tag = 32'hA1; step();
    alu_busy(); mul_rd_addr = 11; mul_data = 32'hD2; mul_tag = 32'hA2; step();
    alu_busy(); mul_rd_addr = 12; mul_data = 32'hD3; mul_tag = 32'hA3;
    chk("fill_ready_low", mul_ready, 0);
    step();
    alu_busy();
    chk("fill_ready_still_low", mul_ready, 0);
    step();
    alu_wr_en = 0;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      m_acc = mul_valid && mul_ready;
      step();
      if (wb_src == 2'b10 && wb_tag == 32'hA3) seen = 1;
      if (m_acc) mul_valid = 0;
    end
    chk("fill_third_retired", seen, 1);
    all_idle();

    // ---- starvation: one MUL entry behind eight ALU writes ----
    do_reset();
    alu_busy(); mul_valid = 1; mul_rd_addr = 6; mul_data = 32'h66; mul_tag = 32'hB1; step();
    mul_valid = 0;
    for (int k = 1; k <= 8; k++) begin
      alu_busy(); step();
      if (k == 7) chk("starve_not_yet", idu_stall_req, 0);
      if (k == 8) chk("starve_asserted", idu_stall_req, 1);
    end
    alu_wr_en = 0; step();
    chk("starve_mul_retired_src", wb_src, 2'b10);
    chk("starve_mul_retired_tag", wb_tag, 32'hB1);
    chk("starve_dropped", idu_stall_req, 0);
    all_idle();

    // ---- reset with both FIFOs full ----
    do_reset();
    for (int k = 0; k < 2; k++) begin
      alu_busy();
      mul_valid = 1; mul_rd_addr = 5'(k + 1); mul_data = $urandom; mul_tag = 32'hC0 + k;
      div_valid = 1; div_rd_addr = 5'(k + 3); div_data = $urandom; div_tag = 32'hE0 + k;
      step();
    end
    mul_valid = 0; div_valid = 0; alu_busy();
    chk("full_mul_ready", mul_ready, 0);
    chk("full_div_ready", div_ready, 0);
    rst = 1; step(); rst = 0;
    chk("rst_rf_wr_en", rf_wr_en, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_mul_ready", mul_ready, 1);
    chk("rst_div_ready", div_ready, 1);
    all_idle();
    for (int k = 0; k < 4; k++) begin
      step();
      chk("rst_no_stale", wb_valid, 0);
    end

    // ---- randomized traffic against the model ----
    m_pend = 0; d_pend = 0;
    for (int c = 0; c < 3000; c++) begin
      case ((c / 64) % 3)
        0: alu_pct = 95;
        1: alu_pct = 50;
        default: alu_pct = 10;
      endcase
      alu_wr_en = ($urandom_range(0, 99) < alu_pct);
      alu_rd_addr = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      alu_data = $urandom; alu_tag = $urandom;
      if (!m_pend && $urandom_range(0, 99) < 40) begin
        m_pend = 1; mul_rd_addr = 5'($urandom_range(0, 31)); mul_data = $urandom; mul_tag = $urandom;
      end
      if (!d_pend && $urandom_range(0, 99) < 30) begin
        d_pend = 1; div_rd_addr = 5'($urandom_range(0, 31)); div_data = $urandom; div_tag = $urandom;
      end
      mul_valid = m_pend; div_valid = d_pend;
      rst = ($urandom_range(0, 199) == 0);
      m_acc = m_pend && mul_ready;
      d_acc = d_pend && div_ready;
      step();
      if (m_acc || rst) m_pend = 0;
      if (d_acc || rst) d_pend = 0;
      rst = 0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
